// File: rtl/bp_be_late_wb_buffer.sv
// ============================================================================
//  Module   : bp_be_late_wb_buffer
//  Purpose  : In-order holding buffer for late (miss-return) load writebacks,
//             presenting the head entry to per-class writeback arbiters.
//  Option   : BP_BE_LATE_WB_BYPASS_EN enables a 0-cycle path when empty.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bp_be_late_wb_buffer #(
  parameter int els_p           = 4,
  parameter int data_width_p    = 64,
  parameter int rd_addr_width_p = 5,
  parameter int num_class_p     = 2,
  parameter int class_width_lp  = (num_class_p > 1) ? $clog2(num_class_p) : 1,
  parameter int count_width_lp  = $clog2(els_p + 1)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,

  input  logic                       v_i,
  output logic                       ready_and_o,
  input  logic [class_width_lp-1:0]  class_i,
  input  logic [rd_addr_width_p-1:0] rd_addr_i,
  input  logic [data_width_p-1:0]    data_i,

  output logic [num_class_p-1:0]     v_o,
  output logic [rd_addr_width_p-1:0] rd_addr_o,
  output logic [data_width_p-1:0]    data_o,
  input  logic [num_class_p-1:0]     yumi_i,

  output logic [count_width_lp-1:0]  count_o,
  output logic                       empty_o
);

  localparam int ptr_width_lp = $clog2(els_p);

  logic [class_width_lp-1:0]  class_mem_q [els_p];
  logic [rd_addr_width_p-1:0] rd_mem_q    [els_p];
  logic [data_width_p-1:0]    data_mem_q  [els_p];

  logic [ptr_width_lp-1:0]    rptr_q, rptr_d;
  logic [ptr_width_lp-1:0]    wptr_q, wptr_d;
  logic [count_width_lp-1:0]  count_q, count_d;

  logic                       full, empty;
  logic                       enq, deq, byp;
  logic                       store_enq, store_deq;
  logic                       head_v;
  logic [class_width_lp-1:0]  head_class;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [ptr_width_lp-1:0] inc_ptr(input logic [ptr_width_lp-1:0] p);
    return (p == ptr_width_lp'(els_p - 1)) ? '0 : p + ptr_width_lp'(1);
  endfunction

  assign full        = (count_q == count_width_lp'(els_p));
  assign empty       = (count_q == '0);
  assign ready_and_o = ~full & ~reset_i;
  assign enq         = v_i & ready_and_o;

`ifdef BP_BE_LATE_WB_BYPASS_EN
  assign byp = empty & enq;
`else
  assign byp = 1'b0;
`endif

  assign head_v     = (~empty | byp) & ~reset_i;
  assign head_class = byp ? class_i   : class_mem_q[rptr_q];
  assign rd_addr_o  = byp ? rd_addr_i : rd_mem_q[rptr_q];
  assign data_o     = byp ? data_i    : data_mem_q[rptr_q];

  for (genvar c = 0; c < num_class_p; c++) begin : g_v_o
    assign v_o[c] = head_v & (head_class == class_width_lp'(c));
  end

  assign deq = |(yumi_i & v_o);

  // A bypassed entry consumed in the same cycle never touches storage.
  assign store_enq = enq & ~(byp & deq);
  assign store_deq = deq & ~byp;

  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (store_enq) wptr_d = inc_ptr(wptr_q);
    if (store_deq) rptr_d = inc_ptr(rptr_q);
    case ({store_enq, store_deq})
      2'b10:   count_d = count_q + count_width_lp'(1);
      2'b01:   count_d = count_q - count_width_lp'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (store_enq) begin
      class_mem_q[wptr_q] <= class_i;
      rd_mem_q[wptr_q]    <= rd_addr_i;
      data_mem_q[wptr_q]  <= data_i;
    end
  end

  assign count_o = count_q;
  assign empty_o = empty;

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(v_i && !ready_and_o))
        else $error("late wb buffer: return dropped while not ready");
      assert ((yumi_i & ~v_o) == '0)
        else $error("late wb buffer: yumi on a class that is not valid");
      assert ($onehot0(yumi_i))
        else $error("late wb buffer: more than one yumi bit set");
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_bp_be_late_wb_buffer.sv
// ============================================================================
//  Module   : tb_bp_be_late_wb_buffer
//  Purpose  : Scoreboard bench for bp_be_late_wb_buffer (depth 4 and depth 3).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bp_be_late_wb_buffer;

`ifdef BP_BE_LATE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic        cls;
    logic [4:0]  rd;
    logic [63:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic reset_i;

  logic        v4, cls4, rdy4, empty4;
  logic [4:0]  rd4, rdo4;
  logic [63:0] d4, do4;
  logic [1:0]  yumi4, vo4;
  logic [2:0]  cnt4;

  logic        v3, cls3, rdy3, empty3;
  logic [4:0]  rd3, rdo3;
  logic [63:0] d3, do3;
  logic [1:0]  yumi3, vo3;
  logic [1:0]  cnt3;

  ent_t q4[$];
  ent_t q3[$];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bp_be_late_wb_buffer #(.els_p(4)) u_dut4 (
    .clk_i(clk), .reset_i(reset_i),
    .v_i(v4), .ready_and_o(rdy4), .class_i(cls4), .rd_addr_i(rd4), .data_i(d4),
    .v_o(vo4), .rd_addr_o(rdo4), .data_o(do4), .yumi_i(yumi4),
    .count_o(cnt4), .empty_o(empty4)
  );

  bp_be_late_wb_buffer #(.els_p(3)) u_dut3 (
    .clk_i(clk), .reset_i(reset_i),
    .v_i(v3), .ready_and_o(rdy3), .class_i(cls3), .rd_addr_i(rd3), .data_i(d3),
    .v_o(vo3), .rd_addr_o(rdo3), .data_o(do3), .yumi_i(yumi3),
    .count_o(cnt3), .empty_o(empty3)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic idle_all();
    v4 = 1'b0; cls4 = 1'b0; rd4 = '0; d4 = '0; yumi4 = '0;
    v3 = 1'b0; cls3 = 1'b0; rd3 = '0; d3 = '0; yumi3 = '0;
  endtask

  // One clock of traffic on the selected instance; checks run before the edge.
  task automatic cycle(input int sel, input bit v, input bit cls, input logic [4:0] rd,
                       input logic [63:0] d, input bit want_deq);
    ent_t hd, inc;
    bit hv, byp, v_eff;
    logic [1:0] yumi, exp_v;
    int sz, els;
    logic o_rdy, o_empty;
    logic [1:0] o_v;
    logic [4:0] o_rd;
    logic [63:0] o_d;
    int o_cnt;

    els   = (sel != 0) ? 3 : 4;
    sz    = (sel != 0) ? q3.size() : q4.size();
    v_eff = v && (sz < els);
    inc   = '{cls: cls, rd: rd, d: d};
    hv = 1'b0; byp = 1'b0; hd = '0;
    if (sz > 0) begin
      hd = (sel != 0) ? q3[0] : q4[0];
      hv = 1'b1;
    end else if (BYP && v_eff) begin
      hd = inc; hv = 1'b1; byp = 1'b1;
    end
    exp_v = hv ? (hd.cls ? 2'b10 : 2'b01) : 2'b00;
    yumi  = (want_deq && hv) ? exp_v : 2'b00;

    idle_all();
    if (sel != 0) begin
      v3 = v_eff; cls3 = cls; rd3 = rd; d3 = d; yumi3 = yumi;
    end else begin
      v4 = v_eff; cls4 = cls; rd4 = rd; d4 = d; yumi4 = yumi;
    end
    #1;
    if (sel != 0) begin
      o_rdy = rdy3; o_empty = empty3; o_v = vo3; o_rd = rdo3; o_d = do3; o_cnt = int'(cnt3);
    end else begin
      o_rdy = rdy4; o_empty = empty4; o_v = vo4; o_rd = rdo4; o_d = do4; o_cnt = int'(cnt4);
    end

    check_eq("ready", 64'(o_rdy), 64'(sz < els));
    check_eq("v_o", 64'(o_v), 64'(exp_v));
    check_eq("count", 64'(o_cnt), 64'(sz));
    check_eq("empty", 64'(o_empty), 64'(sz == 0));
    if (hv) begin
      check_eq("rd_addr", 64'(o_rd), 64'(hd.rd));
      check_eq("data", o_d, hd.d);
    end

    if (yumi != 2'b00 && !byp) begin
      if (sel != 0) void'(q3.pop_front()); else void'(q4.pop_front());
    end
    if (v_eff && !(byp && yumi != 2'b00)) begin
      if (sel != 0) q3.push_back(inc); else q4.push_back(inc);
    end
    @(negedge clk);
  endtask

  initial begin
    idle_all();
    reset_i = 1'b1;
    @(negedge clk);
    #1;
    check_eq("rst_ready", 64'(rdy4), 64'd0);
    check_eq("rst_v_o", 64'(vo4), 64'd0);
    @(negedge clk);
    check_eq("rst_empty", 64'(empty4), 64'd1);
    check_eq("rst_count", 64'(cnt4), 64'd0);
    reset_i = 1'b0;

    // Idle after reset, then a single float return
    cycle(0, 0, 0, 5'd0, 64'd0, 0);
    cycle(0, 1, 1, 5'd7, 64'hDEAD_BEEF, 0);
    cycle(0, 0, 0, 5'd0, 64'd0, 0);
    cycle(0, 0, 0, 5'd0, 64'd0, 1);
    cycle(0, 0, 0, 5'd0, 64'd0, 0);

    // Fill to capacity; dequeue while full, then accept a fifth entry
    for (int i = 0; i < 4; i++) cycle(0, 1, i[0], 5'(10 + i), 64'(64'h1000 + i), 0);
    cycle(0, 0, 0, 5'd0, 64'd0, 1);
    cycle(0, 1, 1, 5'd20, 64'h5555_AAAA, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 5'd0, 64'd0, 1);

    // Int head blocks a float entry behind it until the int drains
    cycle(0, 1, 0, 5'd1, 64'h11, 0);
    cycle(0, 1, 1, 5'd2, 64'h22, 0);
    cycle(0, 1, 0, 5'd3, 64'h33, 0);
    cycle(0, 0, 0, 5'd0, 64'd0, 1);
    cycle(0, 0, 0, 5'd0, 64'd0, 0);
    for (int i = 0; i < 2; i++) cycle(0, 0, 0, 5'd0, 64'd0, 1);

    // Streaming through a depth-3 buffer: pointers wrap past a non-power-of-two
    cycle(1, 1, 0, 5'd4, 64'hA0, 0);
    cycle(1, 1, 1, 5'd5, 64'hA1, 0);
    for (int i = 0; i < 10; i++) cycle(1, 1, i[1], 5'(6 + i), 64'(64'hB0 + i), 1);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 5'd0, 64'd0, 1);

    // Empty buffer, return and consume in the same cycle
    cycle(0, 1, 0, 5'd9, 64'h9999, 1);
    cycle(0, 0, 0, 5'd0, 64'd0, 1);
    cycle(0, 0, 0, 5'd0, 64'd0, 0);

    // Random traffic
    for (int i = 0; i < 80; i++)
      cycle(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom),
            {$urandom, $urandom}, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 5'd0, 64'd0, 1);

    // Reset with entries held discards them
    cycle(0, 1, 1, 5'd12, 64'hC0, 0);
    cycle(0, 1, 0, 5'd13, 64'hC1, 0);
    idle_all();
    reset_i = 1'b1;
    #1;
    check_eq("midrst_ready", 64'(rdy4), 64'd0);
    check_eq("midrst_v_o", 64'(vo4), 64'd0);
    @(negedge clk);
    reset_i = 1'b0;
    q4.delete();
    cycle(0, 0, 0, 5'd0, 64'd0, 0);
    cycle(0, 0, 0, 5'd0, 64'd0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
